clk_en_gen: RTL and testbench
=============================

Name: clk_en_gen

Overview:
- Parametrised multi-channel fractional clock-enable generator.
- Runs from a single PLL output clock and produces NUM_CH independent single-cycle clock-enable strobes at rational ratios num/den. Sub-MHz rates such as CPU and sound clocks no longer need dedicated PLL outputs.
- Qualifies the PLL lock signal and releases a synchronous core reset once lock is stable.
- Channel ratios are reprogrammable at run time through a simple write handshake.

Parameters:
- NUM_CH, 4: number of clock-enable channels, 1..8.
- ACC_W, 24: width of each channel's num, den and accumulator.
- LOCK_CYCLES, 1024: number of consecutive synchronised-locked cycles required before ready asserts. Must be ≥1.
- DEF_NUM, all 0: packed NUM_CH*ACC_W reset numerators; channel i occupies bits [i*ACC_W +: ACC_W].
- DEF_DEN, all 1: packed NUM_CH*ACC_W reset denominators, same packing.

Ports:
- clk_sys, in, 1: system clock (PLL output).
- reset_n, in, 1: asynchronous active-low reset.
- pll_locked, in, 1: raw PLL lock, asynchronous to clk_sys.
- cfg_wr, in, 1: single-cycle ratio write strobe.
- cfg_ch, in, 3: target channel for the write.
- cfg_num, in, ACC_W: new numerator.
- cfg_den, in, ACC_W: new denominator.
- cfg_ack, out, 1: one-cycle write acknowledge.
- cfg_err, out, 1: one-cycle flag for a rejected write.
- ce_out, out, NUM_CH: clock-enable strobes, one bit per channel.
- ready, out, 1: lock qualified; channels running.
- core_rst_n, out, 1: synchronous active-low reset for downstream logic.

Behaviour:
- Reset (reset_n low, asynchronous):
  - ce_out=0, ready=0, core_rst_n=0, cfg_ack=0, cfg_err=0.
  - Accumulators cleared; num/den loaded from DEF_NUM/DEF_DEN; lock counter=0.
- Lock synchroniser: pll_locked passes through a 2-flop synchroniser to give lk_s.
- State machine, states WAIT, COUNT, RUN:
  - WAIT: counter=0. When lk_s=1, go to COUNT.
  - COUNT: counter increments each cycle. If lk_s=0, go to WAIT. When counter reaches LOCK_CYCLES-1, go to RUN.
  - RUN: ready=1. core_rst_n goes high one cycle after ready rises. If lk_s=0, go to WAIT in the same cycle.
  - On leaving RUN: ready=0 and core_rst_n=0 on the next edge. All accumulators clear and ce_out is forced to 0.
- Channel arithmetic, evaluated only while in RUN:
  - sum = acc + num, computed at ACC_W+1 bits.
  - If sum ≥ den: acc ← sum − den and ce_out[i] ← 1. Otherwise acc ← sum and ce_out[i] ← 0.
  - ce_out is registered. The first evaluation happens on the first RUN cycle, and the resulting strobe is visible one cycle later.
  - num=0: ce_out[i] stays 0.
  - num=den: ce_out[i]=1 every cycle.
  - Long-run strobe rate is exactly num/den, with no cumulative drift.
- Config write:
  - cfg_wr is sampled on each edge. The write is valid when cfg_ch < NUM_CH, den ≠ 0 and num ≤ den.
  - Valid write: num/den and acc=0 update on that edge; the channel's ce_out is 0 on the following cycle; cfg_ack=1 on the following cycle.
  - Invalid write: nothing changes; cfg_err=1 on the following cycle and cfg_ack stays 0.
  - Writes are accepted in any state. Only channel cfg_ch is affected; other channels continue undisturbed.
  - A write on the same cycle as lock loss: the ratio update is kept and the accumulator is cleared by the lock-loss rule.
- Back-to-back cfg_wr on consecutive cycles are each handled independently.
- Reset asserted mid-operation: all outputs return to reset values immediately, and ratios revert to the defaults.

Test Plan:
1. Lock qualification (LOCK_CYCLES=16): raise pll_locked → ready=1 exactly 2+16 cycles later; core_rst_n rises one cycle after that. A glitch on pll_locked low for 3 cycles at count 10 → the count restarts from 0.
2. Ratio 3/8 on ch0 → ce_out[0] pulses on RUN evaluation cycles 3, 6 and 8 (1-indexed), repeating every 8 cycles: exactly 300 pulses in 800 cycles.
3. Boundaries: num=0 → no pulses over 1000 cycles. num=den=5 → a pulse every cycle. Writes with num=9, den=8 and with den=0 → cfg_err=1, cfg_ack=0, ratio unchanged.
4. Runtime reprogram: ch1 at 1/4; write 1/2 mid-stream → ack the next cycle; ch1 accumulator restarts from 0 and the next pulse arrives 2 cycles later; ch0 pulse pattern unchanged.
5. Lock loss in RUN: drop pll_locked → ready=0 and all ce_out=0 within 3 cycles. Re-lock → accumulators start from 0 and the first pulses match scenario 2.
6. Async reset mid-run with cfg_wr active → outputs go to zero immediately; after release, DEF_NUM/DEF_DEN ratios are in effect.

Source files
------------

// File: rtl/clk_en_gen.sv
// clk_en_gen
// ----------
// Multi-channel fractional clock-enable generator. It runs from one PLL output
// clock and produces NUM_CH independent single-cycle enable strobes. Each
// strobe fires at the rational rate num/den with no cumulative drift. The PLL
// lock input is synchronised and qualified before the channels run. A
// synchronous active-low core reset is released for downstream logic once
// lock is stable.
//
// Parameters
//   NUM_CH       number of enable channels (1..8)
//   ACC_W        width of each channel's num, den and accumulator
//   LOCK_CYCLES  consecutive synchronised-locked cycles required before ready
//   DEF_NUM      packed reset numerators, channel i at [i*ACC_W +: ACC_W]
//   DEF_DEN      packed reset denominators, same packing
//
// Ports
//   clk_sys     in   system clock (PLL output)
//   reset_n     in   asynchronous active-low reset
//   pll_locked  in   raw PLL lock, asynchronous to clk_sys
//   cfg_wr      in   single-cycle ratio write strobe
//   cfg_ch      in   target channel of the write
//   cfg_num     in   new numerator
//   cfg_den     in   new denominator
//   cfg_ack     out  one-cycle acknowledge of an accepted write
//   cfg_err     out  one-cycle flag for a rejected write
//   ce_out      out  registered clock-enable strobes, one bit per channel
//   ready       out  lock qualified, channels running
//   core_rst_n  out  synchronous active-low reset for downstream logic
//
// Config handshake: cfg_wr is a single-cycle request that needs no ready
// signal, because a write is accepted on every edge in every state. Exactly
// one of cfg_ack / cfg_err pulses on the cycle after each sampled cfg_wr.
// A write is accepted when cfg_ch < NUM_CH, cfg_den != 0 and
// cfg_num <= cfg_den. Writes on consecutive cycles are handled independently.
//
// The lock FSM state is held in the 'state' signal (WAIT/COUNT/RUN), so it
// can be probed directly.

module clk_en_gen #(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = 24,
  parameter int LOCK_CYCLES = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] DEF_NUM = '0,
  parameter logic [NUM_CH*ACC_W-1:0] DEF_DEN = {NUM_CH{{{(ACC_W-1){1'b0}}, 1'b1}}}
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              pll_locked,
  input  logic              cfg_wr,
  input  logic [2:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_num,
  input  logic [ACC_W-1:0]  cfg_den,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ce_out,
  output logic              ready,
  output logic              core_rst_n
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Lock synchroniser
  // ---------------------------------------------------------------------------
  logic lk_s1;
  logic lk_s;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lk_s1 <= 1'b0;
      lk_s  <= 1'b0;
    end else begin
      lk_s1 <= pll_locked;
      lk_s  <= lk_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock qualification FSM
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [31:0]      cnt_ext;
  logic             count_done;
  logic             run_go;

  assign cnt_ext = 32'(cnt);

  // The cycle that moves WAIT->COUNT is the first locked cycle. COUNT
  // therefore finishes when the incremented count reaches LOCK_CYCLES-1, so
  // RUN is entered after exactly LOCK_CYCLES locked cycles.
  assign count_done = (cnt_ext + 32'd1 >= 32'(LOCK_CYCLES - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_WAIT: begin
        cnt_nxt = '0;
        if (lk_s) begin
          state_nxt = (LOCK_CYCLES == 1) ? ST_RUN : ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (!lk_s) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end else if (count_done) begin
          state_nxt = ST_RUN;
          cnt_nxt   = cnt + 1'b1;
        end else begin
          cnt_nxt   = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        cnt_nxt = '0;
        if (!lk_s) begin
          state_nxt = ST_WAIT;
        end
      end
      default: begin
        state_nxt = ST_WAIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign ready = (state == ST_RUN);

  // Channels evaluate only on edges that keep the FSM in RUN. The edge that
  // leaves RUN clears every accumulator and strobe instead.
  assign run_go = (state == ST_RUN) && (state_nxt == ST_RUN);

  // core_rst_n trails ready by one cycle on the way up. It drops on the same
  // edge as ready on the way down.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      core_rst_n <= 1'b0;
    end else begin
      core_rst_n <= run_go;
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration write decode
  // ---------------------------------------------------------------------------
  logic              cfg_ch_ok;
  logic              cfg_valid;
  logic [NUM_CH-1:0] wr_sel;

  assign cfg_ch_ok = ({29'd0, cfg_ch} < 32'(NUM_CH));
  assign cfg_valid = cfg_ch_ok && (cfg_den != '0) && (cfg_num <= cfg_den);

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = cfg_wr && cfg_valid && (cfg_ch == 3'(i));
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_ack <= cfg_wr && cfg_valid;
      cfg_err <= cfg_wr && !cfg_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Channel accumulators
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] num_r [NUM_CH];
  logic [ACC_W-1:0] den_r [NUM_CH];
  logic [ACC_W-1:0] acc_r [NUM_CH];
  logic [ACC_W:0]   sum   [NUM_CH];
  logic [ACC_W-1:0] diff  [NUM_CH];
  logic [NUM_CH-1:0] hit;

  // The invariant acc < den and num <= den gives sum - den < den. The
  // subtraction can therefore be done at ACC_W bits without losing
  // information.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i]  = {1'b0, acc_r[i]} + {1'b0, num_r[i]};
      hit[i]  = (sum[i] >= {1'b0, den_r[i]});
      diff[i] = sum[i][ACC_W-1:0] - den_r[i];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        num_r[i] <= DEF_NUM[i*ACC_W +: ACC_W];
        den_r[i] <= DEF_DEN[i*ACC_W +: ACC_W];
        acc_r[i] <= '0;
      end
      ce_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_sel[i]) begin
          // The new ratio starts from a clean phase. The ratio is kept even
          // if lock is lost on this same edge.
          num_r[i]  <= cfg_num;
          den_r[i]  <= cfg_den;
          acc_r[i]  <= '0;
          ce_out[i] <= 1'b0;
        end else if (run_go) begin
          acc_r[i]  <= hit[i] ? diff[i] : sum[i][ACC_W-1:0];
          ce_out[i] <= hit[i];
        end else begin
          acc_r[i]  <= '0;
          ce_out[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Testbench for clk_en_gen: lock qualification, fractional strobe patterns,
// boundary ratios, config accept/reject, runtime reprogramming, lock loss and
// asynchronous reset.

module tb_clk_en_gen;

  localparam int NUM_CH      = 4;
  localparam int ACC_W       = 24;
  localparam int LOCK_CYCLES = 16;
  // Reset ratios: ch0 1/3, ch1 0/1, ch2 2/2, ch3 3/4
  localparam logic [NUM_CH*ACC_W-1:0] DEF_NUM = {24'd3, 24'd2, 24'd0, 24'd1};
  localparam logic [NUM_CH*ACC_W-1:0] DEF_DEN = {24'd4, 24'd2, 24'd1, 24'd3};

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic              clk_sys;
  logic              reset_n;
  logic              pll_locked;
  logic              cfg_wr;
  logic [2:0]        cfg_ch;
  logic [ACC_W-1:0]  cfg_num;
  logic [ACC_W-1:0]  cfg_den;
  logic              cfg_ack;
  logic              cfg_err;
  logic [NUM_CH-1:0] ce_out;
  logic              ready;
  logic              core_rst_n;

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  clk_en_gen #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (LOCK_CYCLES),
    .DEF_NUM     (DEF_NUM),
    .DEF_DEN     (DEF_DEN)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .cfg_wr     (cfg_wr),
    .cfg_ch     (cfg_ch),
    .cfg_num    (cfg_num),
    .cfg_den    (cfg_den),
    .cfg_ack    (cfg_ack),
    .cfg_err    (cfg_err),
    .ce_out     (ce_out),
    .ready      (ready),
    .core_rst_n (core_rst_n)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and reference ratio model
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  logic [NUM_CH-1:0] exp_q[$];

  longint m_num [NUM_CH];
  longint m_den [NUM_CH];
  longint m_acc [NUM_CH];
  bit     m_run;
  bit     w_pend;
  bit     w_ok;
  int     w_ch;
  longint w_num;
  longint w_den;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_defaults();
    for (int i = 0; i < NUM_CH; i++) begin
      m_num[i] = longint'(DEF_NUM[i*ACC_W +: ACC_W]);
      m_den[i] = longint'(DEF_DEN[i*ACC_W +: ACC_W]);
      m_acc[i] = 0;
    end
    m_run  = 0;
    w_pend = 0;
  endtask

  // Expected strobes produced by the next clock edge.
  function automatic logic [NUM_CH-1:0] model_step();
    logic [NUM_CH-1:0] e;
    e = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_pend && w_ok && (w_ch == i)) begin
        m_num[i] = w_num;
        m_den[i] = w_den;
        m_acc[i] = 0;
      end else if (m_run) begin
        if (m_acc[i] + m_num[i] >= m_den[i]) begin
          m_acc[i] = m_acc[i] + m_num[i] - m_den[i];
          e[i] = 1'b1;
        end else begin
          m_acc[i] = m_acc[i] + m_num[i];
        end
      end else begin
        m_acc[i] = 0;
      end
    end
    w_pend = 0;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic cycle();
    logic [NUM_CH-1:0] e;
    logic [NUM_CH-1:0] want;
    e = model_step();
    exp_q.push_back(e);
    tick();
    want = exp_q.pop_front();
    check("ce_out", 32'(ce_out), 32'(want));
  endtask

  task automatic cfg_write(input int ch, input int num, input int den, input bit ok);
    cfg_wr  = 1'b1;
    cfg_ch  = 3'(ch);
    cfg_num = ACC_W'(num);
    cfg_den = ACC_W'(den);
    w_pend  = 1;
    w_ok    = ok;
    w_ch    = ch;
    w_num   = longint'(num);
    w_den   = longint'(den);
    cycle();
    cfg_wr  = 1'b0;
    check("cfg_ack", 32'(cfg_ack), 32'(ok));
    check("cfg_err", 32'(cfg_err), 32'(!ok));
  endtask

  // Raise lock and expect ready exactly 2 + LOCK_CYCLES cycles later.
  task automatic lock_up();
    pll_locked = 1'b1;
    for (int k = 1; k <= 2 + LOCK_CYCLES; k++) begin
      cycle();
      check("ready_lock", 32'(ready), (k == 2 + LOCK_CYCLES) ? 32'd1 : 32'd0);
    end
    check("core_rst_at_ready", 32'(core_rst_n), 32'd0);
    m_run = 1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] mask;
    int c0;
    int c2;
    int c3;

    reset_n    = 1'b0;
    pll_locked = 1'b0;
    cfg_wr     = 1'b0;
    cfg_ch     = '0;
    cfg_num    = '0;
    cfg_den    = '0;
    model_defaults();

    tick();
    tick();
    check("rst_ce_out", 32'(ce_out), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_cfg_ack", 32'(cfg_ack), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);

    reset_n = 1'b1;
    cycle();
    cycle();
    check("idle_ready", 32'(ready), 32'd0);

    // Lock with a 3-cycle glitch at count 10: the qualification restarts.
    pll_locked = 1'b1;
    for (int k = 0; k < 13; k++) begin
      cycle();
      check("ready_pre_glitch", 32'(ready), 32'd0);
    end
    pll_locked = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("ready_glitch", 32'(ready), 32'd0);
    end
    lock_up();
    cycle();
    check("core_rst_rise", 32'(core_rst_n), 32'd1);
    for (int k = 0; k < 6; k++) cycle();

    // Back-to-back writes: ch2 0/7, ch3 5/5, ch0 3/8.
    cfg_write(2, 0, 7, 1);
    cfg_write(3, 5, 5, 1);
    cfg_write(0, 3, 8, 1);
    mask = '0;
    c0 = 0;
    c2 = 0;
    c3 = 0;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      if (i < 8) mask[i] = ce_out[0];
      if (i < 800) c0 += int'(ce_out[0]);
      c2 += int'(ce_out[2]);
      c3 += int'(ce_out[3]);
    end
    check("ch0_3of8_first8", 32'(mask), 32'h0000_00A4);
    check("ch0_3of8_count800", 32'(c0), 32'd300);
    check("ch2_num0_count1000", 32'(c2), 32'd0);
    check("ch3_5of5_count1000", 32'(c3), 32'd1000);
    check("ack_idle", 32'(cfg_ack), 32'd0);

    // Rejected writes leave every ratio and phase untouched.
    cfg_write(0, 9, 8, 0);
    cfg_write(0, 5, 0, 0);
    cfg_write(5, 1, 2, 0);
    for (int k = 0; k < 16; k++) cycle();

    // Runtime reprogram of ch1: 1/4, then 1/2 mid-stream.
    cfg_write(1, 1, 4, 1);
    for (int k = 0; k < 10; k++) cycle();
    cfg_write(1, 1, 2, 1);
    check("ch1_after_write", 32'(ce_out[1]), 32'd0);
    cycle();
    check("ch1_plus1", 32'(ce_out[1]), 32'd0);
    cycle();
    check("ch1_plus2", 32'(ce_out[1]), 32'd1);
    for (int k = 0; k < 12; k++) cycle();

    // Lock loss in RUN, with a ch1 write on the edge that leaves RUN.
    pll_locked = 1'b0;
    cycle();
    check("ready_loss1", 32'(ready), 32'd1);
    cycle();
    check("ready_loss2", 32'(ready), 32'd1);
    m_run = 0;
    cfg_write(1, 2, 5, 1);
    check("ready_loss3", 32'(ready), 32'd0);
    check("core_rst_loss3", 32'(core_rst_n), 32'd0);
    check("ce_loss3", 32'(ce_out), 32'd0);
    for (int k = 0; k < 2; k++) cycle();

    // Re-lock: ch0 restarts with the 3/8 pattern from a clean phase.
    lock_up();
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i == 0) check("core_rst_relock", 32'(core_rst_n), 32'd1);
      mask[i] = ce_out[0];
    end
    check("ch0_relock_first8", 32'(mask), 32'h0000_00A4);
    for (int k = 0; k < 40; k++) cycle();

    // Asynchronous reset mid-cycle while a valid write is presented.
    cfg_wr  = 1'b1;
    cfg_ch  = 3'd0;
    cfg_num = ACC_W'(1);
    cfg_den = ACC_W'(2);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_ce_out", 32'(ce_out), 32'd0);
    check("arst_ready", 32'(ready), 32'd0);
    check("arst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("arst_cfg_ack", 32'(cfg_ack), 32'd0);
    check("arst_cfg_err", 32'(cfg_err), 32'd0);
    tick();
    cfg_wr  = 1'b0;
    reset_n = 1'b1;
    model_defaults();
    lock_up();
    c0 = 0;
    c2 = 0;
    c3 = 0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (i == 0) check("core_rst_after_arst", 32'(core_rst_n), 32'd1);
      c0 += int'(ce_out[0]);
      c2 += int'(ce_out[2]);
      c3 += int'(ce_out[3]);
    end
    check("def_ch0_1of3", 32'(c0), 32'd8);
    check("def_ch2_2of2", 32'(c2), 32'd24);
    check("def_ch3_3of4", 32'(c3), 32'd18);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
